regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus: two requesters (ALU path, load path) into the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for a register file, with a pending-write
// scoreboard that flags source operands whose producer has not yet written back.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave wb,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] chk_a1,
  input  logic [ADDR_W-1:0] chk_a2,
  output logic              busy_a1,
  output logic              busy_a2,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3
);
  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {LAST_REQ0, LAST_REQ1} last_t;

  last_t             last_grant;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] xaddr;
  logic [DATA_W-1:0] xdata;

  // On a tie the channel that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (wb.req0_valid && (!wb.req1_valid || last_grant == LAST_REQ1))
        grant0 = 1'b1;
      else if (wb.req1_valid)
        grant1 = 1'b1;
    end
  end

  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;
  assign xfer  = grant0 | grant1;
  assign xaddr = grant0 ? wb.req0_addr : wb.req1_addr;
  assign xdata = grant0 ? wb.req0_data : wb.req1_data;

  // Clear first, then set, so a same-cycle issue to the written register wins.
  always_comb begin
    pending_next = pending;
    if (xfer)
      pending_next[xaddr] = 1'b0;
    if (issue_valid && issue_rd != '0)
      pending_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      pending    <= '0;
      last_grant <= LAST_REQ1;
    end else begin
      we3     <= xfer && (xaddr != '0);
      pending <= pending_next;
      if (xfer) begin
        a3         <= xaddr;
        wd3        <= xdata;
        last_grant <= grant1 ? LAST_REQ1 : LAST_REQ0;
      end
    end
  end

  // The in-flight write counts as busy until the register file has captured it.
  always_comb begin
    busy_a1 = (chk_a1 != '0) && (pending[chk_a1] || (we3 && a3 == chk_a1));
    busy_a2 = (chk_a2 != '0) && (pending[chk_a2] || (we3 && a3 == chk_a2));
  end
endmodule
